// File: rtl/switch_evt_pkg.sv
// switch_evt_pkg: event-type codes and index-width helper shared by the switch event arbiter files
package switch_evt_pkg;
  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_LONG    = 2'b11
  } evt_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/switch_evt_channel.sv
// switch_evt_channel: one switch -- 2-flop sync, tick-sampled debounce, long-press counter, pending PRESS/LONG/RELEASE flags (i_clr clears, set wins) and sticky overflow
module switch_evt_channel
  import switch_evt_pkg::*;
#(
  parameter int LONG_PRESS_TICKS = 100
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_switch,
  input  logic       i_tick,
  input  logic [2:0] i_clr,
  output logic       o_debounced,
  output logic [2:0] o_pend,
  output logic       o_overflow
);
  localparam int CNT_W = idx_w(LONG_PRESS_TICKS + 1);
  logic [1:0]       r_sync;
  logic             r_sample, r_deb, r_ovf;
  logic [2:0]       r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic             w_stable, w_rise, w_fall, w_long;
  logic [2:0]       w_set;
  assign w_stable    = i_tick && r_sync[1] == r_sample && r_sync[1] != r_deb;
  assign w_rise      = w_stable && r_sync[1];
  assign w_fall      = w_stable && !r_sync[1];
  assign w_long      = i_tick && r_deb && r_cnt == CNT_W'(LONG_PRESS_TICKS - 1);
  assign w_set       = {w_fall, w_long, w_rise};
  assign o_debounced = r_deb;
  assign o_pend      = r_pend;
  assign o_overflow  = r_ovf;
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync   <= '0;
      r_sample <= 1'b0;
      r_deb    <= 1'b0;
      r_cnt    <= '0;
      r_pend   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_switch};
      if (i_tick) r_sample <= r_sync[1];
      if (w_stable) r_deb <= r_sync[1];
      if (w_rise) r_cnt <= '0;
      else if (i_tick && r_deb && r_cnt != CNT_W'(LONG_PRESS_TICKS)) r_cnt <= r_cnt + 1'b1;
      r_pend <= (r_pend & ~i_clr) | w_set;
      r_ovf  <= r_ovf | |(w_set & r_pend & ~i_clr);
    end
  end
endmodule

// File: rtl/switch_event_arbiter.sv
// switch_event_arbiter: shared-prescaler debounce of i_Switch into o_Debounced, PRESS/LONG/RELEASE events serialised round-robin on o_Evt_Valid/i_Evt_Ready/o_Evt_Sw/o_Evt_Type, sticky o_Overflow
module switch_event_arbiter
  import switch_evt_pkg::*;
#(
  parameter int NUM_SW           = 4,
  parameter int DEBOUNCE_LIMIT   = 250000,
  parameter int LONG_PRESS_TICKS = 100
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_L,
  input  logic [NUM_SW-1:0]          i_Switch,
  output logic [NUM_SW-1:0]          o_Debounced,
  output logic                       o_Evt_Valid,
  input  logic                       i_Evt_Ready,
  output logic [idx_w(NUM_SW)-1:0]   o_Evt_Sw,
  output logic [1:0]                 o_Evt_Type,
  output logic [NUM_SW-1:0]          o_Overflow
);
  localparam int SW_W  = idx_w(NUM_SW);
  localparam int PRE_W = idx_w(DEBOUNCE_LIMIT);
  logic [PRE_W-1:0]         r_pre;
  logic [SW_W-1:0]          r_rr, r_sw, w_sel, w_idx;
  logic                     r_valid, w_tick, w_adv, w_found;
  evt_t                     r_type, w_type;
  logic [2:0]               w_onehot;
  logic [NUM_SW-1:0][2:0]   w_pend, w_clr;
  assign w_tick      = r_pre == PRE_W'(DEBOUNCE_LIMIT - 1);
  assign w_adv       = !r_valid || i_Evt_Ready;
  assign o_Evt_Valid = r_valid;
  assign o_Evt_Sw    = r_sw;
  assign o_Evt_Type  = r_type;
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      w_idx = SW_W'((int'(r_rr) + i) % NUM_SW);
      if (!w_found && |w_pend[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end
  // PRESS before LONG before RELEASE keeps a channel's events in causal order
  assign w_type   = w_pend[w_sel][0] ? EVT_PRESS : w_pend[w_sel][1] ? EVT_LONG : EVT_RELEASE;
  assign w_onehot = w_pend[w_sel][0] ? 3'b001 : w_pend[w_sel][1] ? 3'b010 : 3'b100;
  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    assign w_clr[g] = (w_adv && w_found && w_sel == SW_W'(g)) ? w_onehot : 3'b000;
    switch_evt_channel #(.LONG_PRESS_TICKS(LONG_PRESS_TICKS)) u_ch (
      .i_Clk       (i_Clk),
      .i_Rst_L     (i_Rst_L),
      .i_switch    (i_Switch[g]),
      .i_tick      (w_tick),
      .i_clr       (w_clr[g]),
      .o_debounced (o_Debounced[g]),
      .o_pend      (w_pend[g]),
      .o_overflow  (o_Overflow[g])
    );
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_pre   <= '0;
      r_rr    <= '0;
      r_valid <= 1'b0;
      r_sw    <= '0;
      r_type  <= EVT_NONE;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_adv) begin
        r_valid <= w_found;
        if (w_found) begin
          r_sw   <= w_sel;
          r_type <= w_type;
          r_rr   <= (w_sel == SW_W'(NUM_SW - 1)) ? '0 : w_sel + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_switch_event_arbiter.sv
// tb_switch_event_arbiter: directed scenarios plus random switching checked each clock against a spec-level model
module tb_switch_event_arbiter;
  import switch_evt_pkg::*;
  localparam int N = 4, LIM = 4, LONG = 3;
  logic clk = 0, rst_n = 1, rdy = 0;
  logic [N-1:0] sw = '0, deb, ovf;
  logic vld;
  logic [1:0] sw_o, typ;
  always #5 clk = ~clk;
  switch_event_arbiter #(.NUM_SW(N), .DEBOUNCE_LIMIT(LIM), .LONG_PRESS_TICKS(LONG)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw), .o_Debounced(deb), .o_Evt_Valid(vld),
    .i_Evt_Ready(rdy), .o_Evt_Sw(sw_o), .o_Evt_Type(typ), .o_Overflow(ovf));
  int vectors = 0, errors = 0, cyc = 0, settle;
  typedef struct { int s; int t; int c; } ev_t;
  ev_t log_q[$];
  int tq[$];
  int m_pre, m_rr, m_sw, m_cnt[N];
  bit [N-1:0] m_s1, m_s2, m_samp, m_deb, m_ovf;
  bit [2:0] m_pend[N];
  bit m_vld;
  bit [1:0] m_typ;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  task automatic m_reset();
    m_pre = 0; m_rr = 0; m_sw = 0; m_vld = 0; m_typ = 0;
    m_s1 = 0; m_s2 = 0; m_samp = 0; m_deb = 0; m_ovf = 0;
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_pend[i] = 0; end
  endtask
  task automatic m_step();
    bit tick, adv;
    int pick;
    bit [2:0] set, clr, pclr;
    bit [1:0] pty;
    tick = (m_pre == LIM - 1);
    adv = !m_vld || rdy;
    pick = -1;
    pclr = 0;
    pty = 0;
    for (int i = 0; i < N; i++) if (pick < 0 && m_pend[(m_rr + i) % N] != 0) pick = (m_rr + i) % N;
    if (pick >= 0) begin
      pclr = m_pend[pick][0] ? 3'b001 : m_pend[pick][1] ? 3'b010 : 3'b100;
      pty  = m_pend[pick][0] ? 2'b01  : m_pend[pick][1] ? 2'b11  : 2'b10;
    end
    for (int c = 0; c < N; c++) begin
      set = 0;
      clr = (adv && c == pick) ? pclr : 3'b000;
      if (tick) begin
        if (m_deb[c] && m_cnt[c] < LONG) begin
          m_cnt[c]++;
          if (m_cnt[c] == LONG) set[1] = 1;
        end
        if (m_s2[c] == m_samp[c] && m_s2[c] != m_deb[c]) begin
          if (m_s2[c]) begin set[0] = 1; m_cnt[c] = 0; end
          else set[2] = 1;
          m_deb[c] = m_s2[c];
        end
        m_samp[c] = m_s2[c];
      end
      if ((set & m_pend[c] & ~clr) != 0) m_ovf[c] = 1;
      m_pend[c] = (m_pend[c] & ~clr) | set;
    end
    if (adv) begin
      m_vld = (pick >= 0);
      if (pick >= 0) begin m_sw = pick; m_typ = pty; m_rr = (pick + 1) % N; end
    end
    m_s2 = m_s1;
    m_s1 = sw;
    m_pre = tick ? 0 : m_pre + 1;
  endtask
  task automatic step();
    if (vld && rdy) log_q.push_back('{int'(sw_o), int'(typ), cyc});
    m_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("valid", vld, m_vld);
    if (m_vld) begin
      chk("evt_sw", sw_o, m_sw);
      chk("evt_type", typ, m_typ);
    end
    chk("debounced", deb, m_deb);
    chk("overflow", ovf, m_ovf);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic do_reset();
    rst_n = 0;
    m_reset();
    @(negedge clk);
    chk("reset_valid", vld, 0);
    rst_n = 1;
  endtask
  function automatic int count(input int s, input int t);
    int n = 0;
    foreach (log_q[i]) if (log_q[i].s == s && log_q[i].t == t) n++;
    return n;
  endfunction
  task automatic collect(input int s);
    tq.delete();
    foreach (log_q[i]) if (log_q[i].s == s) tq.push_back(log_q[i].t);
  endtask
  task automatic check_rr(input string tag, input int first);
    chk({tag, "_n"}, log_q.size() >= 4, 1);
    if (log_q.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        chk({tag, "_sw"}, log_q[k].s, (first + k) % N);
        chk({tag, "_type"}, log_q[k].t, EVT_PRESS);
        if (k > 0) chk({tag, "_gap"}, log_q[k].c - log_q[k-1].c, 1);
      end
  endtask
  task automatic check_ppr(input string tag, input int s);
    collect(s);
    chk({tag, "_n"}, tq.size(), 3);
    if (tq.size() == 3) begin
      chk({tag, "_0"}, tq[0], EVT_PRESS);
      chk({tag, "_1"}, tq[1], EVT_LONG);
      chk({tag, "_2"}, tq[2], EVT_RELEASE);
    end
  endtask
  initial begin
    m_reset();
    #1 rst_n = 0;
    for (int i = 0; i < 8; i++) begin
      sw = N'($urandom);
      @(negedge clk);
      chk("rst_valid", vld, 0);
      chk("rst_sw", sw_o, 0);
      chk("rst_type", typ, 0);
      chk("rst_deb", deb, 0);
      chk("rst_ovf", ovf, 0);
    end
    sw = '0;
    @(negedge clk);
    rst_n = 1;
    run(12);
    chk("idle_events", log_q.size(), 0);
    log_q.delete();
    rdy = 1;
    for (int t = 0; t < 20; t++) begin sw[0] = ((t / 3) % 2) == 0; step(); end
    sw[0] = 1;
    settle = cyc;
    run(20);
    chk("bounce_press", count(0, EVT_PRESS), 1);
    chk("bounce_release", count(0, EVT_RELEASE), 0);
    foreach (log_q[i])
      if (log_q[i].s == 0 && log_q[i].t == EVT_PRESS) chk("bounce_latency", log_q[i].c <= settle + 11, 1);
    sw[0] = 0;
    run(25);
    log_q.delete();
    sw[1] = 1;
    run(30);
    sw[1] = 0;
    run(25);
    check_ppr("long", 1);
    do_reset();
    log_q.delete();
    sw = '1;
    run(16);
    check_rr("rr0", 0);
    sw = '0;
    run(30);
    sw[1] = 1;
    run(30);
    sw[1] = 0;
    run(25);
    log_q.delete();
    sw = '1;
    run(16);
    check_rr("rr2", 2);
    sw = '0;
    run(30);
    log_q.delete();
    rdy = 0;
    sw[2] = 1;
    run(40);
    sw[2] = 0;
    run(60);
    chk("bp_no_ovf", ovf, 0);
    chk("bp_held", vld, 1);
    rdy = 1;
    run(10);
    check_ppr("bp", 2);
    chk("bp_total", log_q.size(), 3);
    rdy = 0;
    for (int k = 0; k < 2; k++) begin
      sw[3] = 1;
      run(20);
      sw[3] = 0;
      run(20);
    end
    chk("ovf3", ovf[3], 1);
    chk("ovf_valid", vld, 1);
    #2 rst_n = 0;
    #1;
    chk("async_valid", vld, 0);
    chk("async_ovf", ovf, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) sw[$urandom_range(N - 1)] ^= 1'b1;
      rdy = $urandom_range(3) != 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
